// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-word SDRAM controller with power-up init, periodic
// auto-refresh and close-page (auto-precharge) read/write over a
// valid/ready host port. All DRAM-facing outputs are registered.
module sdram_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ROW_W   = 13,
  parameter int COL_W   = 9,
  parameter int BANK_W  = 2,
  parameter int CAS_LAT = 2,
  parameter int T_INIT  = 10000,
  parameter int T_REFI  = 390,
  parameter int T_RP    = 1,
  parameter int T_RCD   = 1,
  parameter int T_RFC   = 4,
  parameter int T_MRD   = 2,
  parameter int T_WR    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]               req_wdata,
  input  logic [DATA_W/8-1:0]             req_be,
  output logic                            rsp_valid,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic                            init_done,
  output logic                            dram_cke,
  output logic                            dram_cs_n,
  output logic                            dram_ras_n,
  output logic                            dram_cas_n,
  output logic                            dram_we_n,
  output logic [BANK_W-1:0]               dram_ba,
  output logic [ROW_W-1:0]                dram_addr,
  output logic [DATA_W/8-1:0]             dram_dqm,
  output logic [DATA_W-1:0]               dram_dq_o,
  output logic                            dram_dq_oe,
  input  logic [DATA_W-1:0]               dram_dq_i
);

  localparam int ADDR_W  = BANK_W + ROW_W + COL_W;
  localparam int BE_W    = DATA_W / 8;
  localparam int CNT_MAX = (T_INIT > T_REFI) ? T_INIT : T_REFI;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [3:0] ST_INIT_WAIT  = 4'd0;
  localparam logic [3:0] ST_INIT_PRE_W = 4'd1;
  localparam logic [3:0] ST_INIT_REF1  = 4'd2;
  localparam logic [3:0] ST_INIT_REF2  = 4'd3;
  localparam logic [3:0] ST_INIT_MRS_W = 4'd4;
  localparam logic [3:0] ST_IDLE       = 4'd5;
  localparam logic [3:0] ST_REF_W      = 4'd6;
  localparam logic [3:0] ST_ACT        = 4'd7;
  localparam logic [3:0] ST_RCD_W      = 4'd8;
  localparam logic [3:0] ST_WR_W       = 4'd9;
  localparam logic [3:0] ST_RD_W       = 4'd10;

  // Wait-counter reload values: a load of N-1 puts the next command N cycles later.
  localparam logic [CNT_W-1:0] LD_INIT   = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] LD_RP     = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RFC    = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] LD_MRD    = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_RCD    = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_WR     = CNT_W'(T_WR + T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RD     = CNT_W'(CAS_LAT + T_RP);
  localparam logic [CNT_W-1:0] RD_SAMPLE = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] LD_REFI   = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [ROW_W-1:0] A10_MASK  = ROW_W'(1024);
  localparam logic [ROW_W-1:0] MODE_WORD = ROW_W'((CAS_LAT % 8) * 16);

  logic [3:0]        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  ref_cnt;
  logic              ref_pend;
  logic [3:0]        cmd_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic              rd_strobe;
  logic [ROW_W-1:0]  col_word;
  logic              init_last;

  assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;
  assign req_ready = (state == ST_IDLE) && !ref_pend;
  assign init_last = (state == ST_INIT_MRS_W) && (wait_cnt == '0);

  // Column word: zero-extended column with A10 forced for auto-precharge.
  always_comb begin
    col_word = '0;
    col_word[COL_W-1:0] = lat_addr[COL_W-1:0];
    col_word[10] = 1'b1;
  end

  // Refresh interval timer: starts on IDLE entry, raises ref_pend each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else if (init_last) begin
      ref_cnt  <= LD_REFI;
      ref_pend <= 1'b0;
    end else if (init_done) begin
      if (ref_cnt == '0) begin
        ref_cnt  <= LD_REFI;
        ref_pend <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt - CNT_ONE;
        if (state == ST_IDLE && ref_pend) ref_pend <= 1'b0;
      end
    end
  end

  // Main sequencer: init, refresh and access commands plus read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT_WAIT;
      wait_cnt   <= '0;
      cmd_q      <= CMD_NOP;
      dram_cke   <= 1'b0;
      dram_ba    <= '0;
      dram_addr  <= '0;
      dram_dqm   <= '1;
      dram_dq_o  <= '0;
      dram_dq_oe <= 1'b0;
      init_done  <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      rd_strobe  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      cmd_q      <= CMD_NOP;
      dram_dq_oe <= 1'b0;
      dram_dqm   <= init_done ? '0 : '1;
      rd_strobe  <= 1'b0;
      rsp_valid  <= rd_strobe;
      if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_ONE;
      case (state)
        ST_INIT_WAIT: begin
          if (!dram_cke) begin
            dram_cke <= 1'b1;
            wait_cnt <= LD_INIT;
          end else if (wait_cnt == '0) begin
            cmd_q     <= CMD_PRE;
            dram_addr <= A10_MASK;
            wait_cnt  <= LD_RP;
            state     <= ST_INIT_PRE_W;
          end
        end
        ST_INIT_PRE_W: if (wait_cnt == '0) begin
          cmd_q    <= CMD_REF;
          wait_cnt <= LD_RFC;
          state    <= ST_INIT_REF1;
        end
        ST_INIT_REF1: if (wait_cnt == '0) begin
          cmd_q    <= CMD_REF;
          wait_cnt <= LD_RFC;
          state    <= ST_INIT_REF2;
        end
        ST_INIT_REF2: if (wait_cnt == '0) begin
          cmd_q     <= CMD_MRS;
          dram_ba   <= '0;
          dram_addr <= MODE_WORD;
          wait_cnt  <= LD_MRD;
          state     <= ST_INIT_MRS_W;
        end
        ST_INIT_MRS_W: if (wait_cnt == '0) begin
          init_done <= 1'b1;
          dram_dqm  <= '0;
          state     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (ref_pend) begin
            cmd_q    <= CMD_REF;
            wait_cnt <= LD_RFC;
            state    <= ST_REF_W;
          end else if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            state     <= ST_ACT;
          end
        end
        ST_REF_W: if (wait_cnt == '0) state <= ST_IDLE;
        ST_ACT: begin
          cmd_q     <= CMD_ACT;
          dram_ba   <= lat_addr[COL_W+ROW_W +: BANK_W];
          dram_addr <= lat_addr[COL_W +: ROW_W];
          wait_cnt  <= LD_RCD;
          state     <= ST_RCD_W;
        end
        ST_RCD_W: if (wait_cnt == '0) begin
          dram_ba   <= lat_addr[COL_W+ROW_W +: BANK_W];
          dram_addr <= col_word;
          if (lat_we) begin
            cmd_q      <= CMD_WR;
            dram_dq_oe <= 1'b1;
            dram_dq_o  <= lat_wdata;
            dram_dqm   <= ~lat_be;
            wait_cnt   <= LD_WR;
            state      <= ST_WR_W;
          end else begin
            cmd_q    <= CMD_RD;
            wait_cnt <= LD_RD;
            state    <= ST_RD_W;
          end
        end
        ST_WR_W: if (wait_cnt == '0) state <= ST_IDLE;
        ST_RD_W: begin
          if (wait_cnt == RD_SAMPLE) begin
            rsp_rdata <= dram_dq_i;
            rd_strobe <= 1'b1;
          end
          if (wait_cnt == '0) state <= ST_IDLE;
        end
        default: state <= ST_INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: directed bench for sdram_ctrl with a small SDRAM memory model.
module tb_sdram_ctrl;

  localparam int DATA_W  = 16;
  localparam int ROW_W   = 13;
  localparam int COL_W   = 9;
  localparam int BANK_W  = 2;
  localparam int CAS_LAT = 2;
  localparam int T_INIT  = 20;
  localparam int T_REFI  = 100;
  localparam int ADDR_W  = BANK_W + ROW_W + COL_W;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [ADDR_W-1:0] ADDR_A = {2'd1, 13'h123, 9'h045};
  localparam logic [ADDR_W-1:0] ADDR_B = {2'd2, 13'h0AA, 9'h011};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;
  logic              dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
  logic [BANK_W-1:0] dram_ba;
  logic [ROW_W-1:0]  dram_addr;
  logic [1:0]        dram_dqm;
  logic [DATA_W-1:0] dram_dq_o;
  logic              dram_dq_oe;
  logic [DATA_W-1:0] dram_dq_i;
  logic [3:0]        cmd;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cyc_idle = 0;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ROW_W-1:0]  open_row [4];
  int                rd_due = -100;
  logic [DATA_W-1:0] rd_val = '0;

  assign cmd = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};

  sdram_ctrl #(
    .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W),
    .CAS_LAT(CAS_LAT), .T_INIT(T_INIT), .T_REFI(T_REFI),
    .T_RP(1), .T_RCD(1), .T_RFC(4), .T_MRD(2), .T_WR(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .dram_cke(dram_cke), .dram_cs_n(dram_cs_n), .dram_ras_n(dram_ras_n),
    .dram_cas_n(dram_cas_n), .dram_we_n(dram_we_n), .dram_ba(dram_ba),
    .dram_addr(dram_addr), .dram_dqm(dram_dqm), .dram_dq_o(dram_dq_o),
    .dram_dq_oe(dram_dq_oe), .dram_dq_i(dram_dq_i)
  );

  // 100 MHz bench clock and an edge counter for timing checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model: tracks open rows, stores masked writes, drives read data
  // only in the single cycle the controller should sample it.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] key;
    logic [DATA_W-1:0] word;
    if (rst_n) begin
      if (cmd == CMD_ACT) open_row[dram_ba] = dram_addr;
      if (cmd == CMD_WR) begin
        key  = {dram_ba, open_row[dram_ba], dram_addr[COL_W-1:0]};
        word = mem.exists(key) ? mem[key] : '0;
        for (int b = 0; b < 2; b++)
          if (!dram_dqm[b]) word[b*8 +: 8] = dram_dq_o[b*8 +: 8];
        mem[key] = word;
      end
      if (cmd == CMD_RD) begin
        key    = {dram_ba, open_row[dram_ba], dram_addr[COL_W-1:0]};
        rd_val = mem.exists(key) ? mem[key] : '0;
        rd_due = cyc + CAS_LAT;
      end
    end
    dram_dq_i = (cyc == rd_due) ? rd_val : 16'hDEAD;
  end

  // Safety net in case the controller never responds.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Ticks until the given command shows up; n = ticks taken, -1 on timeout.
  task automatic waitCmd(input logic [3:0] c, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (cmd == c) begin
        n = i;
        break;
      end
    end
  endtask

  // Present a request and return right after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [1:0] be);
    int waited;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!req_ready) checkOutput("accept_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic checkInit();
    int n;
    tick();
    checkOutput("init_cke", dram_cke, 1);
    waitCmd(CMD_PRE, T_INIT + 5, n);
    checkOutput("init_pre_delay", n, T_INIT);
    checkOutput("init_pre_a10", dram_addr[10], 1);
    waitCmd(CMD_REF, 10, n);
    checkOutput("init_ref1_delay", n, 1);
    waitCmd(CMD_REF, 10, n);
    checkOutput("init_ref2_delay", n, 4);
    waitCmd(CMD_MRS, 10, n);
    checkOutput("init_mrs_delay", n, 4);
    checkOutput("init_mrs_addr", dram_addr, 32'h020);
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (init_done) begin
        n = i;
        break;
      end
    end
    checkOutput("init_done_delay", n, 2);
    checkOutput("init_dqm", dram_dqm, 0);
    cyc_idle = cyc;
  endtask

  task automatic doRead(input string tag, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] exp_data);
    int n;
    applyStimulus(1'b0, addr, '0, 2'b00);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    checkOutput({tag, "_lat"}, n, 6);
    checkOutput({tag, "_data"}, rsp_rdata, exp_data);
    tick();
    checkOutput({tag, "_pulse"}, rsp_valid, 0);
  endtask

  // Directed sequence: reset, init, write/read, byte masks, refresh, reset abort.
  initial begin
    int accepts, rsps, refs, last_ref, max_gap, min_gap, bad, ready_bad, t_rsp, t_ref;
    logic prev_ready;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    repeat (3) tick();
    checkOutput("rst_cke", dram_cke, 0);
    checkOutput("rst_cmd", cmd, CMD_NOP);
    checkOutput("rst_dqm", dram_dqm, 2'b11);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_init_done", init_done, 0);
    rst_n = 1'b1;
    checkInit();

    // Full-word write, then readback
    applyStimulus(1'b1, ADDR_A, 16'hBEEF, 2'b11);
    tick();
    checkOutput("wr_act_cmd", cmd, CMD_ACT);
    checkOutput("wr_act_ba", dram_ba, 1);
    checkOutput("wr_act_row", dram_addr, 32'h123);
    tick();
    checkOutput("wr_cmd", cmd, CMD_WR);
    checkOutput("wr_addr", dram_addr, 32'h445);
    checkOutput("wr_ba", dram_ba, 1);
    checkOutput("wr_oe", dram_dq_oe, 1);
    checkOutput("wr_dq", dram_dq_o, 32'hBEEF);
    checkOutput("wr_dqm", dram_dqm, 0);
    tick();
    checkOutput("wr_after_oe", dram_dq_oe, 0);
    checkOutput("wr_after_cmd", cmd, CMD_NOP);
    doRead("rd1", ADDR_A, 16'hBEEF);

    // Low byte only
    applyStimulus(1'b1, ADDR_A, 16'h1234, 2'b01);
    tick();
    tick();
    checkOutput("wr2_cmd", cmd, CMD_WR);
    checkOutput("wr2_dqm", dram_dqm, 2'b10);
    doRead("rd2", ADDR_A, 16'hBE34);

    // Back-to-back reads for 300 cycles with refresh interleaved
    accepts = 0; rsps = 0; refs = 0; last_ref = -1;
    max_gap = 0; min_gap = 100000; bad = 0; ready_bad = 0;
    req_we = 1'b0;
    req_addr = ADDR_A;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) accepts++;
      prev_ready = req_ready;
      tick();
      if (rsp_valid) begin
        rsps++;
        if (rsp_rdata !== 16'hBE34) bad++;
      end
      if (cmd == CMD_REF) begin
        refs++;
        if (prev_ready) ready_bad++;
        if (last_ref >= 0) begin
          if (cyc - last_ref > max_gap) max_gap = cyc - last_ref;
          if (cyc - last_ref < min_gap) min_gap = cyc - last_ref;
        end
        last_ref = cyc;
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) begin
        rsps++;
        if (rsp_rdata !== 16'hBE34) bad++;
      end
    end
    checkOutput("burst_no_drop", rsps, accepts);
    checkOutput("burst_enough_accepts", accepts >= 30, 1);
    checkOutput("burst_rdata_bad", bad, 0);
    checkOutput("burst_ref_count", refs >= 2, 1);
    checkOutput("burst_ref_gap_max", max_gap <= T_REFI + 10, 1);
    checkOutput("burst_ref_gap_min", min_gap >= T_REFI - 10, 1);
    checkOutput("burst_ready_before_ref", ready_bad, 0);

    // Refresh falls due while the read waits for data
    for (int i = 0; i < 200; i++) begin
      if (((cyc + 5 - cyc_idle) % T_REFI) == 0) break;
      tick();
    end
    checkOutput("defer_ready", req_ready, 1);
    applyStimulus(1'b0, ADDR_A, '0, 2'b00);
    t_rsp = -1;
    t_ref = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (rsp_valid && t_rsp < 0) t_rsp = i;
      if (cmd == CMD_REF && t_ref < 0) t_ref = i;
    end
    checkOutput("defer_rsp_lat", t_rsp, 6);
    checkOutput("defer_rsp_data", rsp_rdata, 32'hBE34);
    checkOutput("defer_ref_time", t_ref, 7);

    // Reset during the write cycle
    applyStimulus(1'b1, ADDR_B, 16'hA5A5, 2'b11);
    tick();
    tick();
    checkOutput("abort_wr_oe", dram_dq_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_cke", dram_cke, 0);
    checkOutput("abort_cmd", cmd, CMD_NOP);
    checkOutput("abort_dqm", dram_dqm, 2'b11);
    checkOutput("abort_oe", dram_dq_oe, 0);
    checkOutput("abort_addr", dram_addr, 0);
    checkOutput("abort_init_done", init_done, 0);
    checkOutput("abort_ready", req_ready, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    checkInit();
    doRead("rd3", ADDR_A, 16'hBE34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
